// File: rtl/rh_video_pkg.sv
// Shared video constants and pixel types for the rh_video_display
// sprite path (XVGA 1024x768 active, 1344 pixel clocks per line).
package rh_video_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int H_TOTAL  = 1344;
  localparam int PIPE_LAT = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/picture_sprite_if.sv
// Position/frame update handshake between the sprite controller
// and one picture_sprite instance.
interface picture_sprite_if
  import rh_video_pkg::*;
#(
  parameter int FW = 2
);

  logic                update_req;
  logic [HCOUNT_W-1:0] x_in;
  logic [VCOUNT_W-1:0] y_in;
  logic [FW-1:0]       frame_in;
  logic                update_ack;

  modport master (
    output update_req, x_in, y_in, frame_in,
    input  update_ack
  );

  modport slave (
    input  update_req, x_in, y_in, frame_in,
    output update_ack
  );

endinterface

// File: rtl/sprite_palette.sv
// Colour-index to 24-bit RGB lookup, one registered stage.
// Index bits are read as 3-3-2 RGB and replicated up to 8 bits per channel.
module sprite_palette
  import rh_video_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output rgb_t             rgb_o
);

  logic [7:0] idx8;
  rgb_t       rgb_d;
  rgb_t       rgb_q;

  assign idx8 = 8'(idx_i);

  always_comb begin
    rgb_d = '0;
    if (en_i) begin
      rgb_d.r = {idx8[7:5], idx8[7:5], idx8[7:6]};
      rgb_d.g = {idx8[4:2], idx8[4:2], idx8[4:3]};
      rgb_d.b = {4{idx8[1:0]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/picture_sprite.sv
// Animated sprite renderer: vblank-synchronous updates, incremental ROM
// addressing, 3-cycle pipe. PICTURE_SPRITE_TRANSPARENCY_EN keys out TRANS_KEY.
module picture_sprite
  import rh_video_pkg::*;
#(
  parameter int               WIDTH     = 72,
  parameter int               HEIGHT    = 512,
  parameter int               FRAMES    = 4,
  parameter int               IDX_W     = 8,
  parameter int               ADDR_W    = 18,
  parameter logic [IDX_W-1:0] TRANS_KEY = '0
) (
  input  logic                pixel_clk,
  input  logic                reset_n,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  logic                vsync_start,
  picture_sprite_if.slave     upd,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [IDX_W-1:0]    rom_data,
  output rgb_t                pixel,
  output logic                pixel_active
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  localparam logic [HCOUNT_W:0]   W_M1  = (HCOUNT_W+1)'(WIDTH - 1);
  localparam logic [VCOUNT_W:0]   H_M1  = (VCOUNT_W+1)'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0]   W_A   = ADDR_W'(WIDTH);
  localparam logic [HCOUNT_W-1:0] H_ACT = HCOUNT_W'(H_ACTIVE);
  localparam logic [VCOUNT_W-1:0] V_ACT = VCOUNT_W'(V_ACTIVE);

  logic [HCOUNT_W-1:0] act_x_q, act_x_d, pend_x_q, pend_x_d;
  logic [VCOUNT_W-1:0] act_y_q, act_y_d, pend_y_q, pend_y_d;
  logic [FW-1:0]       act_f_q, act_f_d, pend_f_q, pend_f_d;
  logic [FW-1:0]       req_f;
  logic                pending_q, pending_d;
  logic                apply, ack_q;

  logic [ADDR_W-1:0] base_tbl [FRAMES];
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [HCOUNT_W:0] x_last;
  logic [VCOUNT_W:0] y_last;
  logic h_in, v_in, box, vis, line_end;
  logic vis1_q, vis2_q, act_q;
  logic trans_en, drop, pix_en;

  for (genvar g = 0; g < FRAMES; g++) begin : g_base
    assign base_tbl[g] = ADDR_W'(g * WIDTH * HEIGHT);
  end

  assign req_f = (32'(upd.frame_in) >= FRAMES) ?
                 FW'(FRAMES - 1) : upd.frame_in;

  always_comb begin
    apply     = vsync_start && (pending_q || upd.update_req);
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    pend_f_d  = pend_f_q;
    pending_d = pending_q;
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    act_f_d   = act_f_q;
    if (upd.update_req) begin
      pend_x_d  = upd.x_in;
      pend_y_d  = upd.y_in;
      pend_f_d  = req_f;
      pending_d = 1'b1;
    end
    if (apply) begin
      act_x_d   = upd.update_req ? upd.x_in : pend_x_q;
      act_y_d   = upd.update_req ? upd.y_in : pend_y_q;
      act_f_d   = upd.update_req ? req_f    : pend_f_q;
      pending_d = 1'b0;
    end
  end

  // Box limits carry one extra bit so edge-crossing sprites never wrap
  assign x_last = {1'b0, act_x_q} + W_M1;
  assign y_last = {1'b0, act_y_q} + H_M1;

  assign h_in = (hcount >= act_x_q) && ({1'b0, hcount} <= x_last);
  assign v_in = (vcount >= act_y_q) && ({1'b0, vcount} <= y_last);
  assign box  = h_in && v_in;
  assign vis  = box && (hcount < H_ACT) && (vcount < V_ACT);

  assign line_end = v_in && ({1'b0, hcount} == x_last);

  always_comb begin
    line_base_d = line_base_q;
    addr_d      = addr_q;
    if (vsync_start || (vcount < act_y_q)) begin
      line_base_d = base_tbl[act_f_d];
    end else if (line_end) begin
      line_base_d = line_base_q + W_A;
    end
    if (box) begin
      addr_d = line_base_q + ADDR_W'(hcount - act_x_q);
    end
  end

`ifdef PICTURE_SPRITE_TRANSPARENCY_EN
  assign trans_en = 1'b1;
`else
  assign trans_en = 1'b0;
`endif

  assign drop   = trans_en && (rom_data == TRANS_KEY);
  assign pix_en = vis2_q && !drop;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_f_q     <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_f_q    <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      line_base_q <= '0;
      addr_q      <= '0;
      vis1_q      <= 1'b0;
      vis2_q      <= 1'b0;
      act_q       <= 1'b0;
    end else begin
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_f_q     <= act_f_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_f_q    <= pend_f_d;
      pending_q   <= pending_d;
      ack_q       <= apply;
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      vis1_q      <= vis;
      vis2_q      <= vis1_q;
      act_q       <= pix_en;
    end
  end

  sprite_palette #(
    .IDX_W (IDX_W)
  ) u_palette (
    .clk   (pixel_clk),
    .rst_n (reset_n),
    .en_i  (pix_en),
    .idx_i (rom_data),
    .rgb_o (pixel)
  );

  assign rom_addr       = addr_q;
  assign pixel_active   = act_q;
  assign upd.update_ack = ack_q;

endmodule

// File: tb/tb_picture_sprite.sv
// Directed bench for picture_sprite at default parameters; the ROM model
// returns the low address byte one clock after rom_addr.
module tb_picture_sprite;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync_start;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic [23:0] pixel;
  logic        pixel_active;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef PICTURE_SPRITE_TRANSPARENCY_EN
  localparam logic [31:0] EXP_IDX0_ACT = 32'd0;
`else
  localparam logic [31:0] EXP_IDX0_ACT = 32'd1;
`endif

  picture_sprite_if #(.FW(2)) upd ();

  picture_sprite dut (
    .pixel_clk    (pixel_clk),
    .reset_n      (reset_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .vsync_start  (vsync_start),
    .upd          (upd),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pixel        (pixel),
    .pixel_active (pixel_active)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) rom_data <= rom_addr[7:0];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step(input logic [10:0] h, input logic [9:0] v);
    hcount = h;
    vcount = v;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic req(input logic [10:0] x, input logic [9:0] y,
                     input logic [1:0] f, input logic vs);
    upd.update_req = 1'b1;
    upd.x_in       = x;
    upd.y_in       = y;
    upd.frame_in   = f;
    vsync_start    = vs;
    step(11'd0, 10'd0);
    upd.update_req = 1'b0;
    vsync_start    = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    vsync_start    = 1'b0;
    upd.update_req = 1'b0;
    upd.x_in       = '0;
    upd.y_in       = '0;
    upd.frame_in   = '0;
    step(11'd500, 10'd300);
    step(11'd501, 10'd300);
    check("rst_pixel", pixel, 0);
    check("rst_active", pixel_active, 0);
    check("rst_ack", upd.update_ack, 0);
    check("rst_addr", rom_addr, 0);
    reset_n = 1'b1;

    req(11'd100, 10'd50, 2'd0, 1'b0);
    check("ack_no_vsync", upd.update_ack, 0);
    step(11'd0, 10'd0);
    check("ack_still_0", upd.update_ack, 0);
    vsync_start = 1'b1;
    step(11'd0, 10'd0);
    vsync_start = 1'b0;
    check("ack_pulse", upd.update_ack, 1);
    step(11'd0, 10'd0);
    check("ack_one_cycle", upd.update_ack, 0);

    step(11'd100, 10'd50);
    check("addr_first", rom_addr, 0);
    step(11'd101, 10'd50);
    check("lat_not_yet", pixel_active, 0);
    step(11'd102, 10'd50);
    check("lat3_active", pixel_active, EXP_IDX0_ACT);
    check("pix_idx0", pixel, 0);
    for (int h = 103; h <= 107; h++) step(11'(h), 10'd50);
    check("pix_idx5", pixel, 32'h002455);
    check("act_idx5", pixel_active, 1);
    step(11'd171, 10'd50);
    check("addr_last_col", rom_addr, 71);
    step(11'd172, 10'd50);
    check("addr_hold", rom_addr, 71);
    step(11'd173, 10'd50);
    check("pix_col71", pixel, 32'h4924FF);
    step(11'd174, 10'd50);
    check("right_edge_off", pixel_active, 0);
    step(11'd100, 10'd51);
    check("addr_next_line", rom_addr, 72);

    req(11'd300, 10'd60, 2'd1, 1'b0);
    check("ack_pend_only", upd.update_ack, 0);
    step(11'd100, 10'd50);
    check("addr_unchanged", rom_addr, 0);

    req(11'd100, 10'd50, 2'd2, 1'b1);
    check("ack_coincident", upd.update_ack, 1);
    step(11'd100, 10'd50);
    check("addr_frame2", rom_addr, 73728);
    check("ack_clears", upd.update_ack, 0);

    vsync_start = 1'b1;
    step(11'd0, 10'd0);
    vsync_start = 1'b0;
    check("ack_no_pending", upd.update_ack, 0);

    req(11'd100, 10'd50, 2'd3, 1'b0);
    vsync_start = 1'b1;
    step(11'd0, 10'd0);
    vsync_start = 1'b0;
    check("ack_from_pending", upd.update_ack, 1);
    step(11'd100, 10'd50);
    check("addr_frame3", rom_addr, 110592);

    req(11'd1000, 10'd50, 2'd0, 1'b1);
    step(11'd1000, 10'd50);
    check("edge_addr0", rom_addr, 0);
    step(11'd1023, 10'd50);
    check("edge_addr23", rom_addr, 23);
    step(11'd1024, 10'd50);
    step(11'd1025, 10'd50);
    check("edge_1023_on", pixel_active, 1);
    step(11'd1026, 10'd50);
    check("clip_1024", pixel_active, 0);
    step(11'd0, 10'd51);
    step(11'd1, 10'd51);
    step(11'd2, 10'd51);
    check("no_wrap_col0", pixel_active, 0);

    step(11'd1005, 10'd50);
    step(11'd1006, 10'd50);
    step(11'd1007, 10'd50);
    check("pre_reset_active", pixel_active, 1);
    check("pre_reset_pixel", pixel, 32'h002455);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_active", pixel_active, 0);
    check("async_rst_pixel", pixel, 0);
    check("async_rst_addr", rom_addr, 0);
    step(11'd0, 10'd0);
    reset_n = 1'b1;
    step(11'd0, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/picture_sprite.md
# picture_sprite

Parametrised, pipelined successor to the single-image picture block. It renders one rectangular sprite from an external indexed-colour ROM holding several animation frames, with position and frame updates double-buffered so they take effect only at vertical blank. Sits in `rh_video_display` between the XVGA timing generator and the pixel mixer, one instance per sprite.

## Interface
Parameters:
- `WIDTH`, 72, sprite width in pixels.
- `HEIGHT`, 512, sprite height in lines.
- `FRAMES`, 4, animation frames stored back-to-back in ROM.
- `IDX_W`, 8, ROM colour-index width.
- `ADDR_W`, 18, ROM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT*FRAMES.
- `TRANS_KEY`, 8'h00, colour index treated as transparent (see Configuration).

Ports:
- `pixel_clk` in 1: pixel clock. One clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `hcount` in 11: current pixel column.
- `vcount` in 10: current line.
- `vsync_start` in 1: one-cycle pulse at start of vertical blank.
- `update_req` in 1: request to load `x_in`/`y_in`/`frame_in`.
- `x_in` in 11, `y_in` in 10, `frame_in` in clog2(FRAMES): requested position and frame.
- `update_ack` out 1: one-cycle pulse when a request is applied.
- `rom_addr` out ADDR_W: ROM address; ROM returns data one cycle later.
- `rom_data` in IDX_W: ROM colour index.
- `pixel` out 24: {R,G,B}, 0 outside sprite.
- `pixel_active` out 1: high when `pixel` is sprite content.

## Operation
- Shadow regs (`pend_x/y/frame`, `pending`) capture inputs on any cycle with `update_req`=1; later requests before apply overwrite.
- On `vsync_start` with `pending`=1 (or `update_req`=1 same cycle, using those inputs), active regs `act_x/y/frame` load; `pending` clears; `update_ack` pulses next cycle.
- `frame_in` ≥ FRAMES clamps to FRAMES-1 at capture.
- Box test: `hcount` ∈ [act_x, act_x+WIDTH) and `vcount` ∈ [act_y, act_y+HEIGHT); sums computed in 12/11 bits so sprites crossing screen edge never wrap.
- Address generation is incremental, no multiplier: `line_base` loads `act_frame*WIDTH*HEIGHT` (constant table) when `vcount`<act_y; advances by WIDTH on the cycle `hcount`=act_x+WIDTH-1 on an in-box line. `rom_addr` = `line_base` + (`hcount`-act_x) when in box, else holds last value.
- Colour: `rom_data` → palette sub-module (3 × 8-bit maps, registered) → `pixel`.
- Reset: `pixel`=0, `pixel_active`=0, `update_ack`=0, `rom_addr`=0, act/pend regs 0, `pending`=0, `line_base`=0. Reset mid-frame: output black until next in-box pixel after release; first frame may render from address 0 base.

## Timing
- Stage 1: box test + `rom_addr` registered.
- Stage 2: ROM read (external, 1 cycle).
- Stage 3: palette registered → `pixel`/`pixel_active`.
- Total latency: 3 `pixel_clk` from `hcount`/`vcount` to `pixel`; in-box flag delayed through matching 3-stage pipe. Caller delays hsync/vsync/blank by 3.
- Update visible from first in-box pixel of frame following `vsync_start`.

## Configuration
- `PICTURE_SPRITE_TRANSPARENCY_EN` defined: stage-3 `rom_data`==TRANS_KEY forces `pixel`=0, `pixel_active`=0.
- Undefined: every in-box pixel is active, TRANS_KEY ignored.

## Structure
- Shared package `rh_video_pkg`: pixel RGB type, hcount/vcount widths, screen constants (1024×768, H_TOTAL 1344), `PIPE_LAT`=3.
- One sub-module: `sprite_palette` (index → 24-bit RGB, 1-cycle registered).

## Test plan
- Reset with `reset_n`=0 mid-line → `pixel`=0, `pixel_active`=0, `update_ack`=0 immediately.
- Req x=100,y=50,frame=0, vsync pulse; at hcount=100,vcount=50 → `rom_addr`=0 next cycle, `pixel_active`=1 three cycles after; hcount=171 → addr 71; line 51 hcount=100 → addr 72.
- frame=2, WIDTH=72, HEIGHT=512 → first addr 73728; frame_in=7 clamped → 3*36864.
- Req without vsync → no change, no ack; req coincident with vsync_start → applied, ack next cycle.
- x=1000 → right-edge sprite ends at hcount 1023/visible region, no wrap to column 0.
- With TRANSPARENCY_EN, rom_data=8'h00 inside box → `pixel_active`=0; 8'h05 → active.
